// File: rtl/arcade_input_ctrl.sv
// ---------------------------------------------------------------------------
// arcade_input_ctrl
//
// Purpose:
//   Turns raw HPS input (PS/2 key events plus two 16-bit joystick words) into
//   the registered 7-bit player control vectors {coin,start,fire,up,down,
//   left,right} used by the galaxian core. It also contains a timed coin
//   pulse generator. The core therefore sees a clean coin pulse of fixed
//   width followed by a guaranteed low gap, rather than raw start levels.
//
// Ports:
//   clk_sys     in   1   system clock, all logic synchronous to it
//   reset       in   1   asynchronous, active-high reset
//   ps2_key     in  11   [10] event toggle, [9] pressed, [8:0] scan code
//   joystick_0  in  16   [0] R [1] L [2] D [3] U [4] fire [5] start1
//                        [6] start2 [7] coin
//   joystick_1  in  16   same layout as joystick_0
//   rotate      in   1   1 = horizontal cabinet, directions are remapped
//   p1_csjudlr  out  7   {coin,start1,fire,up,down,left,right}
//   p2_csjudlr  out  7   {1'b0,start2,fire,up,down,left,right}
// ---------------------------------------------------------------------------
module arcade_input_ctrl #(
   parameter int COIN_PULSE_CYC = 2400000,
   parameter int COIN_GAP_CYC   = 1200000,
   parameter int CNT_W          = 22
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [10:0] ps2_key,
   input  logic [15:0] joystick_0,
   input  logic [15:0] joystick_1,
   input  logic        rotate,
   output logic [6:0]  p1_csjudlr,
   output logic [6:0]  p2_csjudlr
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } coin_state_t;

   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(COIN_GAP_CYC - 1);

   logic             old_tog;
   logic             armed;
   logic             key_event;
   logic             pressed;
   logic [8:0]       code;

   logic             key_up;
   logic             key_down;
   logic             key_left;
   logic             key_right;
   logic             fire_space;
   logic             fire_ctrl;
   logic             key_start1;
   logic             key_start2;
   logic             coinkey;

   logic [15:0]      joy;
   logic             dir_up;
   logic             dir_down;
   logic             dir_left;
   logic             dir_right;
   logic             out_up;
   logic             out_down;
   logic             out_left;
   logic             out_right;
   logic             fire;
   logic             start1;
   logic             start2;
   logic             creq;
   logic             creq_q;
   logic             coin_req;

   coin_state_t      state;
   coin_state_t      state_next;
   logic [CNT_W-1:0] timer;
   logic [CNT_W-1:0] timer_next;
   logic             pending;
   logic             pending_next;

   logic             unused_joy_bits;

   assign pressed   = ps2_key[9];
   assign code      = ps2_key[8:0];
   assign key_event = armed && (ps2_key[10] != old_tog);

   // The joystick words carry more buttons than the core uses; only the low
   // byte matters here, and the upper byte is folded away deliberately.
   assign unused_joy_bits = ^joy[15:8];

   // Toggle tracking and start-up arming. The very first cycle after reset
   // only captures the current toggle level. A toggle bit left high by the
   // HPS across reset therefore does not look like a fresh key event. The
   // previous coin request level is tracked here as well, for the same reason.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         old_tog <= 1'b0;
         armed   <= 1'b0;
         creq_q  <= 1'b0;
      end else begin
         old_tog <= ps2_key[10];
         armed   <= 1'b1;
         creq_q  <= creq;
      end
   end

   // Key decode. Each event writes its "pressed" flag into the matching key
   // register. Arrow keys arrive with the extended prefix on some keyboards
   // and without it on others, so bit 8 is ignored for them. Every other key
   // must be a plain, non-extended code. Unknown codes leave all keys alone.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         key_up     <= 1'b0;
         key_down   <= 1'b0;
         key_left   <= 1'b0;
         key_right  <= 1'b0;
         fire_space <= 1'b0;
         fire_ctrl  <= 1'b0;
         key_start1 <= 1'b0;
         key_start2 <= 1'b0;
         coinkey    <= 1'b0;
      end else if (key_event) begin
         case (code[7:0])
            8'h75: key_up    <= pressed;
            8'h72: key_down  <= pressed;
            8'h6B: key_left  <= pressed;
            8'h74: key_right <= pressed;
            8'h29: if (!code[8]) fire_space <= pressed;
            8'h14: if (!code[8]) fire_ctrl  <= pressed;
            8'h05: if (!code[8]) key_start1 <= pressed;
            8'h06: if (!code[8]) key_start2 <= pressed;
            8'h2E: if (!code[8]) coinkey    <= pressed;
            default: ;
         endcase
      end
   end

   // Merge keyboard and both joysticks into one set of controls. With a
   // horizontal cabinet the screen is turned a quarter turn, so each stick
   // direction is redirected to the direction the player actually sees.
   // The two fire keys stay independent so that releasing one does not cancel
   // the other. Coin requests come from any start, the coin key, or the
   // joystick coin bit. Only a rising edge seen after arming counts.
   always_comb begin
      joy       = joystick_0 | joystick_1;
      dir_up    = key_up    | joy[3];
      dir_down  = key_down  | joy[2];
      dir_left  = key_left  | joy[1];
      dir_right = key_right | joy[0];
      out_up    = rotate ? dir_left  : dir_up;
      out_down  = rotate ? dir_right : dir_down;
      out_left  = rotate ? dir_down  : dir_left;
      out_right = rotate ? dir_up    : dir_right;
      fire      = fire_space | fire_ctrl | joy[4];
      start1    = key_start1 | joy[5];
      start2    = key_start2 | joy[6];
      creq      = start1 | start2 | coinkey | joy[7];
      coin_req  = armed & creq & ~creq_q;
   end

   // Coin FSM state register. The timer counts down the remaining cycles of
   // the current pulse or gap. The pending flag remembers one request that
   // arrived while busy.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         timer   <= '0;
         pending <= 1'b0;
      end else begin
         state   <= state_next;
         timer   <= timer_next;
         pending <= pending_next;
      end
   end

   // Coin FSM next-state logic. A request while busy is queued at most once,
   // and any further requests are dropped. When the gap runs out, a queued
   // request starts a new pulse straight away. A request that lands exactly
   // on the expiring gap cycle does the same.
   always_comb begin
      state_next   = state;
      timer_next   = timer;
      pending_next = pending;
      case (state)
         IDLE: begin
            if (coin_req) begin
               state_next = PULSE;
               timer_next = PULSE_LOAD;
            end
         end
         PULSE: begin
            if (coin_req) begin
               pending_next = 1'b1;
            end
            if (timer == '0) begin
               state_next = GAP;
               timer_next = GAP_LOAD;
            end else begin
               timer_next = timer - CNT_W'(1);
            end
         end
         GAP: begin
            if (timer == '0) begin
               if (pending || coin_req) begin
                  pending_next = 1'b0;
                  state_next   = PULSE;
                  timer_next   = PULSE_LOAD;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               timer_next = timer - CNT_W'(1);
               if (coin_req) begin
                  pending_next = 1'b1;
               end
            end
         end
         default: begin
            state_next   = IDLE;
            timer_next   = '0;
            pending_next = 1'b0;
         end
      endcase
   end

   // Output registers. Player 2 has no coin line of its own, because the
   // core takes coins only through the player 1 vector.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         p1_csjudlr <= 7'h00;
         p2_csjudlr <= 7'h00;
      end else begin
         p1_csjudlr <= {state == PULSE, start1, fire, out_up, out_down, out_left, out_right};
         p2_csjudlr <= {1'b0, start2, fire, out_up, out_down, out_left, out_right};
      end
   end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// ---------------------------------------------------------------------------
// tb_arcade_input_ctrl
//
// Purpose:
//   Directed testbench for arcade_input_ctrl, run with a short coin pulse
//   (8 cycles) and gap (4 cycles). Every expected value is worked out by hand
//   from the intended behaviour and written into the sequence below.
//
// Ports: none (top-level bench)
// ---------------------------------------------------------------------------
module tb_arcade_input_ctrl;

   logic        clk_sys;
   logic        reset;
   logic [10:0] ps2_key;
   logic [15:0] joystick_0;
   logic [15:0] joystick_1;
   logic        rotate;
   logic [6:0]  p1_csjudlr;
   logic [6:0]  p2_csjudlr;

   int          vectors;
   int          miscompares;
   logic        tog;

   arcade_input_ctrl #(
      .COIN_PULSE_CYC (8),
      .COIN_GAP_CYC   (4),
      .CNT_W          (22)
   ) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .ps2_key    (ps2_key),
      .joystick_0 (joystick_0),
      .joystick_1 (joystick_1),
      .rotate     (rotate),
      .p1_csjudlr (p1_csjudlr),
      .p2_csjudlr (p2_csjudlr)
   );

   // Free-running 100 MHz-style clock; the absolute rate is irrelevant here.
   initial begin
      clk_sys = 1'b0;
      forever #5 clk_sys = ~clk_sys;
   end

   // Advance one clock and land just after the edge. Inputs are driven and
   // outputs are sampled at this point, well away from the active edge.
   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Drive the joystick words and the rotation input.
   task automatic applyStimulus(input logic [15:0] j0, input logic [15:0] j1, input logic rot);
      joystick_0 = j0;
      joystick_1 = j1;
      rotate     = rot;
   endtask

   // Present one PS/2 key event by flipping the toggle bit.
   task automatic pressKey(input logic [8:0] code, input logic pressed);
      tog     = ~tog;
      ps2_key = {tog, pressed, code};
   endtask

   // Compare one output against its hand-computed value.
   task automatic checkOutput(input string tag, input logic [6:0] observed, input logic [6:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Directed sequence, one step after another.
   initial begin
      vectors     = 0;
      miscompares = 0;
      tog         = 1'b1;
      reset       = 1'b1;
      ps2_key     = 11'h400;
      applyStimulus(16'h0000, 16'h0000, 1'b0);

      // Reset state, with the toggle bit already high.
      tick();
      tick();
      checkOutput("reset_p1", p1_csjudlr, 7'h00);
      checkOutput("reset_p2", p2_csjudlr, 7'h00);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         checkOutput($sformatf("no_spurious_%0d", i), p1_csjudlr, 7'h00);
      end

      // Extended up arrow, then rotation, then release.
      pressKey(9'h175, 1'b1);
      tick();
      checkOutput("up_latency1", p1_csjudlr, 7'h00);
      tick();
      checkOutput("up_pressed", p1_csjudlr, 7'h08);
      checkOutput("up_p2", p2_csjudlr, 7'h08);
      applyStimulus(16'h0000, 16'h0000, 1'b1);
      tick();
      checkOutput("up_rotated", p1_csjudlr, 7'h01);
      pressKey(9'h175, 1'b0);
      tick();
      tick();
      checkOutput("up_released", p1_csjudlr, 7'h00);
      applyStimulus(16'h0000, 16'h0000, 1'b0);
      tick();

      // Plain down arrow works without the extended bit.
      pressKey(9'h072, 1'b1);
      tick();
      tick();
      checkOutput("down_pressed", p1_csjudlr, 7'h04);
      pressKey(9'h072, 1'b0);
      tick();
      tick();
      checkOutput("down_released", p1_csjudlr, 7'h00);

      // Extended space and unknown codes change nothing.
      pressKey(9'h129, 1'b1);
      tick();
      tick();
      checkOutput("ext_space_ignored", p1_csjudlr, 7'h00);
      pressKey(9'h01C, 1'b1);
      tick();
      tick();
      checkOutput("unknown_ignored", p1_csjudlr, 7'h00);

      // Two fire keys overlap.
      pressKey(9'h029, 1'b1);
      tick();
      tick();
      checkOutput("fire_space", p1_csjudlr, 7'h10);
      pressKey(9'h014, 1'b1);
      tick();
      tick();
      checkOutput("fire_both", p1_csjudlr, 7'h10);
      pressKey(9'h029, 1'b0);
      tick();
      tick();
      checkOutput("fire_ctrl_only", p1_csjudlr, 7'h10);
      pressKey(9'h014, 1'b0);
      tick();
      tick();
      checkOutput("fire_none", p1_csjudlr, 7'h00);

      // One-cycle start1 on joystick 0 gives one 8-cycle coin pulse.
      applyStimulus(16'h0020, 16'h0000, 1'b0);
      tick();
      checkOutput("start1_seen", p1_csjudlr, 7'h20);
      applyStimulus(16'h0000, 16'h0000, 1'b0);
      for (int i = 0; i < 8; i++) begin
         tick();
         checkOutput($sformatf("coin_high_%0d", i), p1_csjudlr, 7'h40);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         checkOutput($sformatf("coin_low_%0d", i), p1_csjudlr, 7'h00);
      end

      // Held start2 on joystick 1 gives exactly one pulse.
      applyStimulus(16'h0000, 16'h0040, 1'b0);
      tick();
      checkOutput("start2_p2", p2_csjudlr, 7'h20);
      checkOutput("start2_p1", p1_csjudlr, 7'h00);
      for (int i = 0; i < 8; i++) begin
         tick();
         checkOutput($sformatf("held_coin_high_%0d", i), p1_csjudlr, 7'h40);
      end
      for (int i = 0; i < 12; i++) begin
         tick();
         checkOutput($sformatf("held_coin_low_%0d", i), p1_csjudlr, 7'h00);
      end
      checkOutput("start2_still_held", p2_csjudlr, 7'h20);
      applyStimulus(16'h0000, 16'h0000, 1'b0);
      tick();
      checkOutput("start2_released", p2_csjudlr, 7'h00);
      tick();

      // Coin edges at steps 1, 3 and 5: two pulses with a 4-cycle gap.
      for (int c = 1; c <= 30; c++) begin
         applyStimulus((c == 1 || c == 3 || c == 5) ? 16'h0080 : 16'h0000, 16'h0000, 1'b0);
         tick();
         checkOutput($sformatf("queue_%0d", c), p1_csjudlr,
                     ((c >= 2 && c <= 9) || (c >= 14 && c <= 21)) ? 7'h40 : 7'h00);
      end

      // A request on the exact cycle the gap expires restarts immediately.
      for (int c = 1; c <= 30; c++) begin
         applyStimulus((c == 1 || c == 13) ? 16'h0080 : 16'h0000, 16'h0000, 1'b0);
         tick();
         checkOutput($sformatf("gap_edge_%0d", c), p1_csjudlr,
                     ((c >= 2 && c <= 9) || (c >= 14 && c <= 21)) ? 7'h40 : 7'h00);
      end

      // Reset mid-pulse with the coin still held.
      applyStimulus(16'h0080, 16'h0000, 1'b0);
      tick();
      tick();
      checkOutput("pre_reset_high1", p1_csjudlr, 7'h40);
      tick();
      checkOutput("pre_reset_high2", p1_csjudlr, 7'h40);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("async_reset_drop", p1_csjudlr, 7'h00);
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         checkOutput($sformatf("held_after_reset_%0d", i), p1_csjudlr, 7'h00);
      end

      // Releasing and pressing again re-arms the coin.
      applyStimulus(16'h0000, 16'h0000, 1'b0);
      tick();
      applyStimulus(16'h0080, 16'h0000, 1'b0);
      tick();
      checkOutput("rearm_latency", p1_csjudlr, 7'h00);
      tick();
      checkOutput("rearm_pulse", p1_csjudlr, 7'h40);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
